// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice: index-mode encodings,
// counter reset value and the BTB entry layout.
package bp_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Counters come out of reset one step below the taken threshold.
  function automatic int weak_not_taken(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // Tag field is sized for the smallest BTB; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/bp_btb_dm.sv
// Direct-mapped branch target buffer: one combinational lookup port reading
// pre-write contents and one registered write port; valid bits clear on reset.
module bp_btb_dm
  import bp_pkg::*;
#(
  parameter int BTB_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int ENTRIES = 1 << BTB_BITS;
  localparam int TAG_W   = 30 - BTB_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [BTB_BITS-1:0] rd_set;
  logic [BTB_BITS-1:0] wr_set;
  btb_entry_t          rd_entry;
  logic                unused_pc_bits;

  assign rd_set = rd_pc[BTB_BITS+1:2];
  assign wr_set = wr_pc[BTB_BITS+1:2];
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  always_comb begin
    rd_entry        = '0;
    rd_entry.valid  = valid_q[rd_set];
    rd_entry.tag    = 30'(tag_q[rd_set]);
    rd_entry.target = target_q[rd_set];
  end

  assign rd_hit    = rd_entry.valid && (rd_entry.tag == 30'(rd_pc[31:BTB_BITS+2]));
  assign rd_target = rd_entry.target;

  // Only the valid bits need a reset; tag/target are qualified by them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_set]    <= wr_pc[31:BTB_BITS+2];
      target_q[wr_set] <= wr_target;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal direction predictor with a direct-mapped BTB, speculative and
// architectural global history, and a one-cycle registered prediction.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PHT_BITS = 10,
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int BTB_BITS = 6,
  parameter int MODE     = MODE_GSHARE
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FLUSH,
  input  logic                Lk_valid,
  input  logic [31:0]         Lk_pc,
  input  logic                Lk_is_branch,
  input  logic                Lk_is_jump,
  output logic                Taken,
  output logic [31:0]         Taken_addr,
  output logic [PHT_BITS-1:0] Pred_idx,
  input  logic                Up_valid,
  input  logic [31:0]         Up_pc,
  input  logic                Up_is_branch,
  input  logic                Up_is_jump,
  input  logic                Up_taken,
  input  logic [31:0]         Up_target,
  input  logic [PHT_BITS-1:0] Up_idx,
  input  logic                Up_mispredict
);

  localparam int                  PHT_ENTRIES = 1 << PHT_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WNT     = CTR_BITS'(weak_not_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

  logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0] spec_ghr_q;
  logic [GHR_BITS-1:0] arch_ghr_q;
  logic [GHR_BITS-1:0] spec_ghr_next;
  logic [GHR_BITS-1:0] arch_ghr_next;
  logic [PHT_BITS-1:0] ghr_mix;
  logic [PHT_BITS-1:0] lk_idx;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_next;
  logic                btb_hit;
  logic [31:0]         btb_target;
  logic                lk_taken;
  logic                up_branch;
  logic                up_btb_wr;

  assign ghr_mix   = (MODE == MODE_GSHARE) ? PHT_BITS'(spec_ghr_q) : '0;
  assign lk_idx    = Lk_pc[PHT_BITS+1:2] ^ ghr_mix;
  assign up_branch = Up_valid && Up_is_branch;
  assign up_btb_wr = Up_valid && ((Up_is_branch && Up_taken) || Up_is_jump);

  bp_btb_dm #(
    .BTB_BITS (BTB_BITS)
  ) u_btb (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_pc     (Lk_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (up_btb_wr),
    .wr_pc     (Up_pc),
    .wr_target (Up_target)
  );

  // Lookup reads the PHT and BTB as they stand before this cycle's update.
  always_comb begin
    lk_taken = 1'b0;
    if (Lk_valid) begin
      if (Lk_is_jump) begin
        lk_taken = btb_hit;
      end else if (Lk_is_branch) begin
        lk_taken = btb_hit && pht_q[lk_idx][CTR_BITS-1];
      end
    end
  end

  always_comb begin
    ctr_cur  = pht_q[Up_idx];
    ctr_next = ctr_cur;
    if (Up_taken && (ctr_cur != CTR_MAX)) begin
      ctr_next = ctr_cur + CTR_BITS'(1);
    end else if (!Up_taken && (ctr_cur != '0)) begin
      ctr_next = ctr_cur - CTR_BITS'(1);
    end
  end

  // A mispredict or flush resynchronises speculative history to the
  // architectural history including this cycle's resolved branch.
  always_comb begin
    arch_ghr_next = arch_ghr_q;
    if (up_branch) begin
      arch_ghr_next = (arch_ghr_q << 1) | GHR_BITS'(Up_taken);
    end
    spec_ghr_next = spec_ghr_q;
    if ((Up_valid && Up_mispredict) || FLUSH) begin
      spec_ghr_next = arch_ghr_next;
    end else if (Lk_valid && Lk_is_branch) begin
      spec_ghr_next = (spec_ghr_q << 1) | GHR_BITS'(lk_taken);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Taken      <= 1'b0;
      Taken_addr <= '0;
      Pred_idx   <= '0;
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_next;
      arch_ghr_q <= arch_ghr_next;
      if (FLUSH) begin
        Taken      <= 1'b0;
        Taken_addr <= '0;
        Pred_idx   <= '0;
      end else begin
        Taken      <= lk_taken;
        Taken_addr <= lk_taken ? btb_target : '0;
        Pred_idx   <= Lk_valid ? lk_idx : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CTR_WNT;
      end
    end else if (up_branch) begin
      pht_q[Up_idx] <= ctr_next;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench driving a bimodal and a gshare instance with identical
// stimulus against a behavioural predictor model.
module tb_gshare_predictor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH, Lk_valid, Lk_is_branch, Lk_is_jump;
  logic [31:0] Lk_pc;
  logic        Up_valid, Up_is_branch, Up_is_jump, Up_taken, Up_mispredict;
  logic [31:0] Up_pc, Up_target;
  logic [9:0]  Up_idx;

  logic        taken0, taken1;
  logic [31:0] addr0, addr1;
  logic [9:0]  idx0, idx1;
  logic [85:0] obs;

  typedef struct packed {
    logic        t0;
    logic [31:0] a0;
    logic [9:0]  i0;
    logic        t1;
    logic [31:0] a1;
    logic [9:0]  i1;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;

  int unsigned m_pht [1024];
  bit          m_btb_v [64];
  logic [23:0] m_btb_tag [64];
  logic [31:0] m_btb_tgt [64];
  logic [7:0]  m_spec [2];
  logic [7:0]  m_arch;

  always #5 CLK = ~CLK;
  assign obs = {taken0, addr0, idx0, taken1, addr1, idx1};

  gshare_predictor #(.MODE(0)) dut_bimodal (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .Lk_valid(Lk_valid), .Lk_pc(Lk_pc), .Lk_is_branch(Lk_is_branch), .Lk_is_jump(Lk_is_jump),
    .Taken(taken0), .Taken_addr(addr0), .Pred_idx(idx0),
    .Up_valid(Up_valid), .Up_pc(Up_pc), .Up_is_branch(Up_is_branch), .Up_is_jump(Up_is_jump),
    .Up_taken(Up_taken), .Up_target(Up_target), .Up_idx(Up_idx), .Up_mispredict(Up_mispredict)
  );

  gshare_predictor #(.MODE(1)) dut_gshare (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .Lk_valid(Lk_valid), .Lk_pc(Lk_pc), .Lk_is_branch(Lk_is_branch), .Lk_is_jump(Lk_is_jump),
    .Taken(taken1), .Taken_addr(addr1), .Pred_idx(idx1),
    .Up_valid(Up_valid), .Up_pc(Up_pc), .Up_is_branch(Up_is_branch), .Up_is_jump(Up_is_jump),
    .Up_taken(Up_taken), .Up_target(Up_target), .Up_idx(Up_idx), .Up_mispredict(Up_mispredict)
  );

  task automatic idle_inputs();
    FLUSH = 0; Lk_valid = 0; Lk_is_branch = 0; Lk_is_jump = 0; Lk_pc = '0;
    Up_valid = 0; Up_is_branch = 0; Up_is_jump = 0; Up_taken = 0;
    Up_pc = '0; Up_target = '0; Up_idx = '0; Up_mispredict = 0;
  endtask

  task automatic set_lookup(input logic [31:0] pc, input logic br, input logic jmp);
    Lk_valid = 1; Lk_pc = pc; Lk_is_branch = br; Lk_is_jump = jmp;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic br, input logic jmp,
                            input logic tk, input logic [31:0] tgt, input logic [9:0] idx,
                            input logic mp);
    Up_valid = 1; Up_pc = pc; Up_is_branch = br; Up_is_jump = jmp;
    Up_taken = tk; Up_target = tgt; Up_idx = idx; Up_mispredict = mp;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 64; i++) m_btb_v[i] = 0;
    m_spec[0] = '0; m_spec[1] = '0; m_arch = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 0;
    model_reset();
    @(negedge CLK);
    RESET = 1;
  endtask

  // Runs the model for the inputs currently applied, pushes the expectation,
  // and clocks the DUTs once; returns at the following falling edge.
  task automatic apply_stimulus();
    logic [7:0] arch_n;
    logic [7:0] spec_n [2];
    arch_n = m_arch;
    if (Up_valid && Up_is_branch) arch_n = {m_arch[6:0], Up_taken};
    for (int m = 0; m < 2; m++) begin
      logic [9:0] idx;
      logic       hit, tk;
      int         b;
      idx = Lk_pc[11:2] ^ ((m == 1) ? {2'b00, m_spec[m]} : 10'd0);
      b   = int'(Lk_pc[7:2]);
      hit = m_btb_v[b] && (m_btb_tag[b] == Lk_pc[31:8]);
      tk  = 0;
      if (Lk_valid && Lk_is_jump) tk = hit;
      else if (Lk_valid && Lk_is_branch) tk = hit && (m_pht[idx] >= 2);
      if (m == 0) begin
        e.t0 = !FLUSH && tk;
        e.a0 = (!FLUSH && tk) ? m_btb_tgt[b] : 32'd0;
        e.i0 = (!FLUSH && Lk_valid) ? idx : 10'd0;
      end else begin
        e.t1 = !FLUSH && tk;
        e.a1 = (!FLUSH && tk) ? m_btb_tgt[b] : 32'd0;
        e.i1 = (!FLUSH && Lk_valid) ? idx : 10'd0;
      end
      if ((Up_valid && Up_mispredict) || FLUSH) spec_n[m] = arch_n;
      else if (Lk_valid && Lk_is_branch) spec_n[m] = {m_spec[m][6:0], tk};
      else spec_n[m] = m_spec[m];
    end
    if (Up_valid && Up_is_branch) begin
      if (Up_taken && m_pht[Up_idx] < 3) m_pht[Up_idx]++;
      else if (!Up_taken && m_pht[Up_idx] > 0) m_pht[Up_idx]--;
    end
    if (Up_valid && ((Up_is_branch && Up_taken) || Up_is_jump)) begin
      m_btb_v[Up_pc[7:2]]   = 1;
      m_btb_tag[Up_pc[7:2]] = Up_pc[31:8];
      m_btb_tgt[Up_pc[7:2]] = Up_target;
    end
    m_arch = arch_n;
    m_spec[0] = spec_n[0];
    m_spec[1] = spec_n[1];
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    #2 RESET = 0;
    #1;
    n_cmp++;
    if (obs !== 86'd0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %h want 0", obs);
    end
    @(negedge CLK);
    n_cmp++;
    if (obs !== 86'd0) begin
      n_fail++; $display("[TB] FAIL reset_held: got %h want 0", obs);
    end
    RESET = 1;
  endtask

  task automatic test_basic_lookup();
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL cold_lookup: got %h want %h", obs, e); end
    n_cmp++;
    if (taken0 !== 1'b0 || addr0 !== 32'h0 || idx0 !== 10'h100) begin
      n_fail++; $display("[TB] FAIL cold_lookup_const: got %b/%h/%h want 0/0/100", taken0, addr0, idx0);
    end
    set_update(32'h400, 0, 1, 1, 32'h480, 10'h100, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL jump_fill: got %h want %h", obs, e); end
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL weak_nt_branch: got %h want %h", obs, e);
    end
    set_lookup(32'h400, 0, 1);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b1 || addr0 !== 32'h480) begin
      n_fail++; $display("[TB] FAIL jump_hit: got %h want %h", obs, e);
    end
  endtask

  task automatic test_train_taken();
    do_reset();
    repeat (2) begin
      set_update(32'h400, 1, 0, 1, 32'h480, 10'h100, 0);
      apply_stimulus(); e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL train_update: got %h want %h", obs, e); end
    end
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL trained_lookup: got %h want %h", obs, e); end
    n_cmp++;
    if (taken0 !== 1'b1 || addr0 !== 32'h480 || idx0 !== 10'h100) begin
      n_fail++; $display("[TB] FAIL trained_const: got %b/%h/%h want 1/480/100", taken0, addr0, idx0);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 9; k++) begin
      set_update(32'h400, 1, 0, (k >= 4 && k < 8), 32'h480, 10'h100, 0);
      apply_stimulus(); e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL sat_update%0d: got %h want %h", k, obs, e); end
      set_lookup(32'h400, 1, 0);
      apply_stimulus(); e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL sat_lookup%0d: got %h want %h", k, obs, e); end
      if (k == 4) begin
        n_cmp++;
        if (taken0 !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_floor: got %b want 0", taken0); end
      end
      if (k == 8) begin
        n_cmp++;
        if (taken0 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_ceiling: got %b want 1", taken0); end
      end
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_update(32'h400, 0, 1, 1, 32'h480, 10'h100, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mp_fill: got %h want %h", obs, e); end
    set_update(32'h400, 1, 0, 1, 32'h480, 10'h100, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mp_train_a: got %h want %h", obs, e); end
    set_update(32'h404, 1, 0, 1, 32'h480, 10'h101, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mp_train_b: got %h want %h", obs, e); end
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken1 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mp_predict_taken: got %h want %h", obs, e);
    end
    set_lookup(32'h400, 1, 0);
    set_update(32'h400, 1, 0, 0, 32'h480, 10'h100, 1);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mp_resolve: got %h want %h", obs, e); end
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mp_after: got %h want %h", obs, e); end
    n_cmp++;
    if (idx1 !== 10'h106) begin n_fail++; $display("[TB] FAIL mp_ghr_restore: got %h want 106", idx1); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_update(32'h14, 0, 1, 1, 32'h200, 10'd5, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sc_fill: got %h want %h", obs, e); end
    set_lookup(32'h14, 1, 0);
    set_update(32'h14, 1, 0, 1, 32'h200, 10'd5, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sc_pre_update: got %h want %h", obs, e);
    end
    set_lookup(32'h14, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b1 || addr0 !== 32'h200) begin
      n_fail++; $display("[TB] FAIL sc_post_update: got %h want %h", obs, e);
    end
  endtask

  task automatic test_no_class();
    set_update(32'h14, 0, 0, 0, 32'h990, 10'd5, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL nc_update: got %h want %h", obs, e); end
    set_lookup(32'h14, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b1 || addr0 !== 32'h200) begin
      n_fail++; $display("[TB] FAIL nc_unchanged: got %h want %h", obs, e);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_update(32'h400, 0, 1, 1, 32'h480, 10'h100, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL fl_fill: got %h want %h", obs, e); end
    set_lookup(32'h400, 0, 1);
    set_update(32'h400, 1, 0, 1, 32'h480, 10'h100, 0);
    FLUSH = 1;
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || obs !== 86'd0) begin
      n_fail++; $display("[TB] FAIL fl_zero: got %h want %h", obs, e);
    end
    set_lookup(32'h400, 0, 1);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b1 || addr0 !== 32'h480) begin
      n_fail++; $display("[TB] FAIL fl_btb_kept: got %h want %h", obs, e);
    end
    set_lookup(32'h400, 1, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || idx1 !== 10'h101) begin
      n_fail++; $display("[TB] FAIL fl_ghr_sync: got %h want %h", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [5];
    logic [31:0] upc;
    int          r;
    pcs[0] = 32'h400; pcs[1] = 32'h14; pcs[2] = 32'h1400; pcs[3] = 32'h84; pcs[4] = 32'h2014;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        r = int'($urandom_range(0, 9));
        set_lookup(pcs[$urandom_range(0, 4)], r < 5, r >= 5 && r < 7);
      end
      if ($urandom_range(0, 2) != 0) begin
        upc = pcs[$urandom_range(0, 4)];
        r = int'($urandom_range(0, 9));
        set_update(upc, r < 6, r >= 6 && r < 8, 1'($urandom_range(0, 1)),
                   32'h1000 + 32'($urandom_range(0, 15)) * 4,
                   upc[11:2] ^ 10'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
      end
      FLUSH = ($urandom_range(0, 19) == 0);
      apply_stimulus(); e = sb.pop_front(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL b2b_cycle%0d: got %h want %h", n, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    set_update(32'h400, 0, 1, 1, 32'h480, 10'h100, 0);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL ar_fill: got %h want %h", obs, e); end
    set_lookup(32'h400, 0, 1);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_hit: got %h want %h", obs, e); end
    #2 RESET = 0;
    #1;
    n_cmp++;
    if (obs !== 86'd0) begin n_fail++; $display("[TB] FAIL ar_immediate: got %h want 0", obs); end
    model_reset();
    @(negedge CLK);
    RESET = 1;
    set_lookup(32'h400, 0, 1);
    apply_stimulus(); e = sb.pop_front(); n_cmp++;
    if (obs !== e || taken0 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ar_btb_cleared: got %h want %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lookup();
    test_train_taken();
    test_saturation();
    test_mispredict();
    test_same_cycle();
    test_no_class();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
